// File: rtl/count_seq_ctrl.sv
// rtl/count_seq_ctrl.sv - run sequencer for the WIDTH-bit up-counter datapath
// Accepts target/prescale, clears the counter, paces its enable, and reports done/aborted.
module count_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int PW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] target,
  input  logic [PW-1:0]    prescale,
  input  logic             pause,
  input  logic             abort,
  input  logic [WIDTH-1:0] count,
  output logic             cnt_clr,
  output logic             cnt_en,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [PW-1:0]    psc_q, psc_d;
  logic [PW-1:0]    pre_cnt_q, pre_cnt_d;
  logic             aborted_q, aborted_d;
  logic             run_en;
  logic             last_step;

  // Widened compare so a target of all-ones still completes without wrap.
  always_comb begin
    run_en    = (state_q == RUN) && !pause && !abort && (pre_cnt_q == psc_q);
    last_step = (({1'b0, count} + {{WIDTH{1'b0}}, 1'b1}) == {1'b0, tgt_q});
  end

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    psc_d     = psc_q;
    pre_cnt_d = pre_cnt_q;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          tgt_d   = target;
          psc_d   = prescale;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        pre_cnt_d = '0;
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else begin
          state_d = (tgt_q == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (run_en) begin
          pre_cnt_d = '0;
          if (last_step) state_d = DONE;
        end else if (!pause) begin
          pre_cnt_d = pre_cnt_q + PW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tgt_q     <= '0;
      psc_q     <= '0;
      pre_cnt_q <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      psc_q     <= psc_d;
      pre_cnt_q <= pre_cnt_d;
      aborted_q <= aborted_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign cnt_clr     = (state_q == CLEAR);
  assign cnt_en      = run_en;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign aborted     = aborted_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb/tb_count_seq_ctrl.sv - directed self-checking bench for count_seq_ctrl
// Pairs the controller with a behavioural counter and checks per-cycle output traces.
module tb_count_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int PW    = 4;

  logic             clk;
  logic             reset;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] target;
  logic [PW-1:0]    prescale;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             cnt_clr;
  logic             cnt_en;
  logic             busy;
  logic             done;
  logic             aborted;

  int total = 0;
  int bad   = 0;

  logic [63:0]      tr_en, tr_clr, tr_done, tr_abt, tr_busy, tr_rdy;
  logic [WIDTH-1:0] tr_cnt [0:63];

  count_seq_ctrl #(.WIDTH(WIDTH), .PW(PW)) dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .target(target), .prescale(prescale),
    .pause(pause), .abort(abort), .count(count),
    .cnt_clr(cnt_clr), .cnt_en(cnt_en),
    .busy(busy), .done(done), .aborted(aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter being sequenced: synchronous clear has priority over enable.
  always @(posedge clk or posedge reset) begin
    if (reset)        count <= '0;
    else if (cnt_clr) count <= '0;
    else if (cnt_en)  count <= count + 8'd1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Cycle 0 is the accept cycle when sv_m[0] is set; inputs change after the falling edge.
  task automatic run_cmd(input logic [WIDTH-1:0] t, input logic [PW-1:0] p,
                         input logic [63:0] sv_m, input logic [63:0] pause_m,
                         input logic [63:0] abort_m, input int ncyc);
    tr_en = '0; tr_clr = '0; tr_done = '0; tr_abt = '0; tr_busy = '0; tr_rdy = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      start_valid = sv_m[c];
      target      = t;
      prescale    = p;
      pause       = pause_m[c];
      abort       = abort_m[c];
      #1;
      tr_en[c]   = cnt_en;
      tr_clr[c]  = cnt_clr;
      tr_done[c] = done;
      tr_abt[c]  = aborted;
      tr_busy[c] = busy;
      tr_rdy[c]  = start_ready;
      tr_cnt[c]  = count;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"}, 64'(start_ready), 64'd1);
    check({tag, "_clr"}, 64'(cnt_clr), 64'd0);
    check({tag, "_en"},  64'(cnt_en), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_abt"}, 64'(aborted), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start_valid = 1'b0; target = '0; prescale = '0; pause = 1'b0; abort = 1'b0;
    #2;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b0;

    // Basic run: target 3, prescale 0
    run_cmd(8'd3, 4'd0, 64'h1, 64'h0, 64'h0, 8);
    check("basic_clr", tr_clr, 64'h02);
    check("basic_en", tr_en, 64'h1C);
    check("basic_done", tr_done, 64'h20);
    check("basic_cnt5", 64'(tr_cnt[5]), 64'd3);
    check("basic_busy", tr_busy, 64'h3E);
    check("basic_rdy", tr_rdy, 64'hC1);
    check("basic_abt", tr_abt, 64'h0);

    // Prescale: target 2, prescale 2
    run_cmd(8'd2, 4'd2, 64'h1, 64'h0, 64'h0, 10);
    check("psc_en", tr_en, 64'h90);
    check("psc_done", tr_done, 64'h100);
    check("psc_cnt8", 64'(tr_cnt[8]), 64'd2);
    check("psc_busy", tr_busy, 64'h1FE);

    // Pause high in cycles 3-4
    run_cmd(8'd2, 4'd0, 64'h1, 64'h18, 64'h0, 8);
    check("pause_en", tr_en, 64'h24);
    check("pause_done", tr_done, 64'h40);
    check("pause_cnt6", 64'(tr_cnt[6]), 64'd2);
    check("pause_busy", tr_busy, 64'h7E);

    // Abort in cycle 4, re-accept in cycle 5, abort that run during RUN in cycle 7
    run_cmd(8'd10, 4'd0, 64'h21, 64'h0, 64'h90, 10);
    check("abt_en", tr_en, 64'h0C);
    check("abt_pulse", tr_abt, 64'h120);
    check("abt_done", tr_done, 64'h0);
    check("abt_cnt5", 64'(tr_cnt[5]), 64'd2);
    check("abt_clr", tr_clr, 64'h42);
    check("abt_rdy", tr_rdy, 64'h321);
    check("abt_busy", tr_busy, 64'hDE);
    check("abt_cnt9", 64'(tr_cnt[9]), 64'd0);

    // Zero target with start_valid held high
    run_cmd(8'd0, 4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 6);
    check("zero_rdy", tr_rdy, 64'h09);
    check("zero_clr", tr_clr, 64'h12);
    check("zero_done", tr_done, 64'h24);
    check("zero_en", tr_en, 64'h0);
    check("zero_busy", tr_busy, 64'h36);

    // Long run, then asynchronous reset while an enable is active
    run_cmd(8'd255, 4'd15, 64'h1, 64'h0, 64'h0, 34);
    check("long_en", tr_en, 64'h0000_0002_0002_0000);
    check("long_busy", tr_busy, 64'h3_FFFF_FFFE);
    check("long_cnt33", 64'(tr_cnt[33]), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("arst");
    @(negedge clk);
    reset = 1'b0;

    // Fresh command after reset: target 1, prescale 1
    run_cmd(8'd1, 4'd1, 64'h1, 64'h0, 64'h0, 6);
    check("rec_clr", tr_clr, 64'h02);
    check("rec_en", tr_en, 64'h08);
    check("rec_done", tr_done, 64'h10);
    check("rec_cnt4", 64'(tr_cnt[4]), 64'd1);
    check("rec_abt", tr_abt, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
